// File: rtl/alu_exec_unit.sv
// Integer ALU execute stage: decodes ctrl_ALU_op/funct3/funct7 into one ALU operation, registers result/zero/illegal.
// Latency: 1 cycle for every op; MUL (only with ALU_MUL_EN) spends XLEN cycles in MUL, so out_valid appears XLEN+1 cycles after accept.
// Backpressure: in_ready drops while a result is held without out_ready and throughout MUL; a held result keeps result/zero/illegal stable.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready request handshake carrying ctrl_ALU_op, funct3,
//        funct7, op_a, op_b; out_valid/out_ready result handshake carrying result, zero, illegal.
// Build option: define ALU_MUL_EN to add the shift-add multiplier (R-type funct7 0000001, funct3 000).
module alu_exec_unit #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ctrl_ALU_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    typedef enum logic [1:0] {ST_IDLE, ST_RESULT, ST_MUL} state_t;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
    } alu_op_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;

    alu_op_t           dec_op;
    logic [XLEN-1:0]   alu_res;
    logic [SHW-1:0]    shamt;
    logic              accept;

`ifdef ALU_MUL_EN
    localparam logic [SHW-1:0] MUL_LAST = SHW'(XLEN - 1);

    logic [XLEN-1:0]   mul_acc_q, mul_acc_d;
    logic [XLEN-1:0]   mul_mcand_q, mul_mcand_d;
    logic [XLEN-1:0]   mul_mplier_q, mul_mplier_d;
    logic [SHW-1:0]    mul_cnt_q, mul_cnt_d;
    logic [XLEN-1:0]   mul_step;
`endif

    // Common funct3 map shared by R-type and I-type ALU ops.
    function automatic alu_op_t base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op = OP_ADD;
        case (ctrl_ALU_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct7)
                    7'b0000000: dec_op = base_op(funct3);
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec_op = OP_SUB;
                        else if (funct3 == 3'b101) dec_op = OP_SRA;
                        else                       dec_op = OP_ILL;
                    end
                    7'b0000001: begin
`ifdef ALU_MUL_EN
                        dec_op = (funct3 == 3'b000) ? OP_MUL : OP_ILL;
`else
                        dec_op = OP_ILL;
`endif
                    end
                    default: dec_op = OP_ILL;
                endcase
            end
            default: begin
                // I-type: funct7 only matters for shifts (it is the upper immediate field otherwise).
                dec_op = base_op(funct3);
                if (funct3 == 3'b101 && funct7[5])
                    dec_op = OP_SRA;
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    dec_op = OP_ILL;
            end
        endcase
    end

    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (dec_op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_OR:   alu_res = op_a | op_b;
            OP_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;   // illegal (and MUL, which does not use this path)
        endcase
    end

    // A held result frees the unit in the same cycle the consumer takes it.
    assign in_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_RESULT && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
    assign mul_step = mul_mplier_q[0] ? (mul_acc_q + mul_mcand_q) : mul_acc_q;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
`ifdef ALU_MUL_EN
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
`endif

        // Leaving RESULT without a new request drops back to IDLE.
        if (state_q == ST_RESULT && out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end

        if (accept) begin
`ifdef ALU_MUL_EN
            if (dec_op == OP_MUL) begin
                // Result registers keep their old value until the product is done.
                state_d      = ST_MUL;
                out_valid_d  = 1'b0;
                mul_acc_d    = '0;
                mul_mcand_d  = op_a;
                mul_mplier_d = op_b;
                mul_cnt_d    = '0;
            end else
`endif
            begin
                state_d     = ST_RESULT;
                out_valid_d = 1'b1;
                result_d    = alu_res;
                zero_d      = (alu_res == '0);
                illegal_d   = (dec_op == OP_ILL);
            end
        end

`ifdef ALU_MUL_EN
        if (state_q == ST_MUL) begin
            mul_acc_d    = mul_step;
            mul_mcand_d  = mul_mcand_q << 1;
            mul_mplier_d = mul_mplier_q >> 1;
            mul_cnt_d    = mul_cnt_q + 1'b1;
            if (mul_cnt_q == MUL_LAST) begin
                state_d     = ST_RESULT;
                out_valid_d = 1'b1;
                result_d    = mul_step;
                zero_d      = (mul_step == '0);
                illegal_d   = 1'b0;
                mul_cnt_d   = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
